mult_iter_pipe: RTL



---
 rtl/mult_pkg.sv | 31 +++
 rtl/mult_slice16.sv | 17 +
 rtl/mult_iter_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants, FSM state type and chunk-count helper for
//                the iterative slice multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Width of the single shared slice multiplier.
    localparam int SLICE_W = 16;

    // Multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Number of SLICE_W-bit chunks per operand. A width that is not a
    // positive multiple of SLICE_W yields 0, which the top turns into an
    // elaboration error.
    function automatic int calc_n(input int w);
        if ((w >= SLICE_W) && ((w % SLICE_W) == 0)) begin
            return w / SLICE_W;
        end
        return 0;
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_slice16.sv
`default_nettype none
// ============================================================================
//  Module      : mult_slice16
//  Description : Combinational 16x16 unsigned multiply, 32-bit result.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_slice16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);

    // Full-precision unsigned partial product.
    assign o_p = 32'(i_a) * 32'(i_b);

endmodule : mult_slice16
`default_nettype wire

// File: rtl/mult_iter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_iter_pipe
//  Description : W x W -> 2W multi-cycle multiplier. Operand magnitudes are
//                split into 16-bit chunks; one shared 16x16 slice multiplier
//                processes one chunk pair per cycle (N*N cycles) with shifted
//                accumulation, and the sign is applied at the end.
//  Options     : MULT_ITER_EARLY_ZERO_EN - a zero operand finishes after a
//                single CALC cycle instead of N*N.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_iter_pipe
    import mult_pkg::*;
#(
    parameter int W     = 32,
    parameter int SLICE = SLICE_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    localparam int N  = calc_n(W);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

    // Reject unsupported widths at elaboration.
    generate
        if ((N == 0) || (SLICE != SLICE_W)) begin : g_bad_width
            $error("mult_iter_pipe: W must be a positive multiple of 16");
        end
    endgenerate

    mult_state_t    r_state;
    mult_state_t    w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_neg;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_product;
    logic [IW-1:0]  r_i;
    logic [IW-1:0]  r_j;

    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic           w_neg;
    logic [15:0]    w_a_chunk;
    logic [15:0]    w_b_chunk;
    logic [31:0]    w_pp;
    logic [2*W-1:0] w_pp_wide;
    logic [2*W-1:0] w_acc_next;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = r_product;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_i == c_last_idx) && (r_j == c_last_idx);

    // Signed mode works on magnitudes; -2^(W-1) negates to itself, which is
    // exactly 2^(W-1) when read as unsigned.
    assign w_a_mag = (in_signed && A[W-1]) ? (-A) : A;
    assign w_b_mag = (in_signed && B[W-1]) ? (-B) : B;
    assign w_neg   = in_signed && (A[W-1] ^ B[W-1]);

    assign w_a_chunk = r_a[int'(r_i)*SLICE +: SLICE];
    assign w_b_chunk = r_b[int'(r_j)*SLICE +: SLICE];

    mult_slice16 u_slice (
        .i_a (w_a_chunk),
        .i_b (w_b_chunk),
        .o_p (w_pp)
    );

    // Position the partial product at chunk weight (i+j) and accumulate.
    always_comb begin
        w_pp_wide  = (2*W)'(w_pp) << (SLICE * (int'(r_i) + int'(r_j)));
        w_acc_next = r_acc + w_pp_wide;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)                w_state_next = CALC;
            CALC:    if (w_last)                  w_state_next = DONE;
            DONE:    if (out_ready)               w_state_next = IDLE;
            default:                              w_state_next = IDLE;
        endcase
    end

    // Operand capture, chunk sequencing, accumulation and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_a_mag;
                        r_b   <= w_b_mag;
                        r_neg <= w_neg;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
`ifdef MULT_ITER_EARLY_ZERO_EN
                        // A zero operand makes every partial product zero, so
                        // start at the final chunk pair and finish in one cycle.
                        if ((A == '0) || (B == '0)) begin
                            r_i <= c_last_idx;
                            r_j <= c_last_idx;
                        end
`endif
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    if (r_j == c_last_idx) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                    if (w_last) begin
                        r_product <= r_neg ? (-w_acc_next) : w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : mult_iter_pipe
`default_nettype wire
